// File: rtl/dbg_pkg.sv
// Shared definitions for the core debug controller: register map indices,
// CTRL/STATUS bit positions and the run-control state encoding.
package dbg_pkg;

    localparam int REG_CYCLE_L = 0;
    localparam int REG_CYCLE_H = 1;
    localparam int REG_CTRL    = 2;
    localparam int REG_STEPS   = 3;
    localparam int REG_STATUS  = 4;
    localparam int REG_BP0     = 5;

    localparam int CTRL_STEP_MODE = 0;
    localparam int CTRL_HALT_REQ  = 1;
    localparam int CTRL_RESUME    = 2;
    localparam int CTRL_BP_EN0    = 3;

    localparam int STATUS_BP_HIT  = 2;
    localparam int STATUS_BP_IDX  = 8;

    typedef enum logic [1:0] {
        DBG_RUN  = 2'd0,
        DBG_HALT = 2'd1,
        DBG_STEP = 2'd2
    } dbg_state_e;

endpackage

// File: rtl/dbg_read_port.sv
// One slave read port: decodes a word index against the shared register view
// and holds the result in a register until the next read strobe.
module dbg_read_port
    import dbg_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int MAP_WORDS = 12
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        rd_i,
    input  logic [ADDR_W-3:0]           widx_i,
    input  logic [MAP_WORDS-1:0][31:0]  view_i,
    output logic [31:0]                 rdata_o
);

    logic [31:0] rdata_d, rdata_q;

    // Indices past the end of the map fall through to zero.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_i) begin
            rdata_d = '0;
            for (int w = 0; w < MAP_WORDS; w++) begin
                if (int'(widx_i) == w) rdata_d = view_i[w];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/core_debug_ctrl.sv
// Memory-mapped debug controller: run/halt/step control through a core clock
// enable, PC breakpoints, enabled-cycle counter and read-only probe words.
module core_debug_ctrl
    import dbg_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int NUM_PROBES = 5,
    parameter int NUM_BP     = 2,
    parameter int CYCLE_W    = 64,
    parameter int ADDR_W     = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_PORTS*ADDR_W-1:0] s_address,
    input  logic [NUM_PORTS-1:0]       s_read,
    output logic [NUM_PORTS*32-1:0]    s_readdata,
    input  logic [NUM_PORTS-1:0]       s_write,
    input  logic [NUM_PORTS*32-1:0]    s_writedata,
    input  logic [NUM_PROBES*32-1:0]   probe_in,
    input  logic [31:0]                pc_if,
    output logic                       core_en,
    output logic                       halted,
    output logic                       bp_hit
);

    localparam int WIDX_W    = ADDR_W - 2;
    localparam int PROBE0    = REG_BP0 + NUM_BP;
    localparam int MAP_WORDS = PROBE0 + NUM_PROBES;
    localparam int CTRL_W    = CTRL_BP_EN0 + NUM_BP;

    if (MAP_WORDS > (1 << WIDX_W)) begin : g_map_chk
        $error("core_debug_ctrl: register map exceeds the port address space");
    end
    if (CYCLE_W < 33 || CYCLE_W > 64) begin : g_cyc_chk
        $error("core_debug_ctrl: CYCLE_W must be 33..64");
    end

    dbg_state_e                  state_q;
    logic [CYCLE_W-1:0]          cycle_q;
    logic                        step_mode_q;
    logic [NUM_BP-1:0]           bp_en_q;
    logic [31:0]                 steps_q;
    logic [NUM_BP-1:0][31:0]     bp_addr_q;
    logic                        bp_hit_q, bp_skip_q;
    logic [7:0]                  bp_idx_q;

    logic                        ctrl_we, steps_we;
    logic [CTRL_W-1:0]           ctrl_wd;
    logic [31:0]                 steps_wd;
    logic [NUM_BP-1:0]           bp_we;
    logic [NUM_BP-1:0][31:0]     bp_wd;
    logic [WIDX_W-1:0]           widx;

    // Walk ports from highest to lowest so the lowest index is the last writer.
    always_comb begin
        ctrl_we  = 1'b0;
        ctrl_wd  = '0;
        steps_we = 1'b0;
        steps_wd = '0;
        bp_we    = '0;
        bp_wd    = '0;
        widx     = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            widx = s_address[p*ADDR_W+2 +: WIDX_W];
            if (s_write[p]) begin
                if (widx == WIDX_W'(REG_CTRL)) begin
                    ctrl_we = 1'b1;
                    ctrl_wd = s_writedata[p*32 +: CTRL_W];
                end
                if (widx == WIDX_W'(REG_STEPS)) begin
                    steps_we = 1'b1;
                    steps_wd = s_writedata[p*32 +: 32];
                end
                for (int k = 0; k < NUM_BP; k++) begin
                    if (widx == WIDX_W'(REG_BP0 + k)) begin
                        bp_we[k] = 1'b1;
                        bp_wd[k] = s_writedata[p*32 +: 32];
                    end
                end
            end
        end
    end

    logic       halt_req, resume, bp_any, bp_match;
    logic [7:0] bp_first;

    assign halt_req = ctrl_we && ctrl_wd[CTRL_HALT_REQ];
    assign resume   = ctrl_we && ctrl_wd[CTRL_RESUME];

    always_comb begin
        bp_any   = 1'b0;
        bp_first = '0;
        for (int k = NUM_BP - 1; k >= 0; k--) begin
            if (bp_en_q[k] && pc_if == bp_addr_q[k]) begin
                bp_any   = 1'b1;
                bp_first = 8'(k);
            end
        end
    end

    assign bp_match = bp_any && !bp_skip_q;
    assign core_en  = (state_q == DBG_RUN && !bp_match && !halt_req && !step_mode_q)
                   || state_q == DBG_STEP;
    assign halted   = (state_q == DBG_HALT);
    assign bp_hit   = bp_hit_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= DBG_RUN;
            cycle_q     <= '0;
            step_mode_q <= 1'b0;
            bp_en_q     <= '0;
            steps_q     <= '0;
            bp_addr_q   <= '0;
            bp_hit_q    <= 1'b0;
            bp_skip_q   <= 1'b0;
            bp_idx_q    <= '0;
        end else begin
            if (core_en) begin
                cycle_q   <= cycle_q + CYCLE_W'(1);
                bp_skip_q <= 1'b0;
            end
            if (ctrl_we) begin
                step_mode_q <= ctrl_wd[CTRL_STEP_MODE];
                bp_en_q     <= ctrl_wd[CTRL_BP_EN0 +: NUM_BP];
            end
            for (int k = 0; k < NUM_BP; k++) begin
                if (bp_we[k]) bp_addr_q[k] <= bp_wd[k];
            end
            if (steps_we) steps_q <= steps_wd;

            case (state_q)
                DBG_RUN: begin
                    if (halt_req || step_mode_q || bp_match) begin
                        state_q <= DBG_HALT;
                        if (bp_match) begin
                            bp_hit_q <= 1'b1;
                            bp_idx_q <= bp_first;
                        end
                    end
                end
                DBG_HALT: begin
                    // Resume checks the step_mode bit written alongside it.
                    if (steps_q != 32'd0) begin
                        state_q <= DBG_STEP;
                    end else if (resume && !ctrl_wd[CTRL_STEP_MODE]) begin
                        state_q   <= DBG_RUN;
                        bp_hit_q  <= 1'b0;
                        bp_skip_q <= 1'b1;
                    end
                end
                DBG_STEP: begin
                    if (halt_req) begin
                        state_q <= DBG_HALT;
                        steps_q <= '0;
                    end else if (steps_we) begin
                        if (steps_wd == 32'd0) state_q <= DBG_HALT;
                    end else if (steps_q <= 32'd1) begin
                        state_q <= DBG_HALT;
                        steps_q <= '0;
                    end else begin
                        steps_q <= steps_q - 32'd1;
                    end
                end
                default: state_q <= DBG_RUN;
            endcase
        end
    end

    logic [MAP_WORDS-1:0][31:0] view;

    always_comb begin
        view              = '0;
        view[REG_CYCLE_L] = cycle_q[31:0];
        view[REG_CYCLE_H] = 32'(cycle_q[CYCLE_W-1:32]);
        view[REG_CTRL]    = 32'({bp_en_q, 2'b00, step_mode_q});
        view[REG_STEPS]   = steps_q;
        view[REG_STATUS]  = {16'h0, bp_idx_q, 5'h0, bp_hit_q, state_q};
        for (int k = 0; k < NUM_BP; k++) view[REG_BP0 + k] = bp_addr_q[k];
        for (int i = 0; i < NUM_PROBES; i++) view[PROBE0 + i] = probe_in[i*32 +: 32];
    end

    logic [NUM_PORTS*2-1:0] unused_addr_lsbs;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
        assign unused_addr_lsbs[p*2 +: 2] = s_address[p*ADDR_W +: 2];

        dbg_read_port #(
            .ADDR_W    (ADDR_W),
            .MAP_WORDS (MAP_WORDS)
        ) u_rd (
            .clk_i   (clk),
            .rst_i   (reset),
            .rd_i    (s_read[p]),
            .widx_i  (s_address[p*ADDR_W+2 +: WIDX_W]),
            .view_i  (view),
            .rdata_o (s_readdata[p*32 +: 32])
        );
    end

endmodule

// File: tb/tb_core_debug_ctrl.sv
// Directed bench for core_debug_ctrl: a register-level model checked every
// cycle, plus hand-computed expectations along the scripted sequence.
module tb_core_debug_ctrl;

    localparam int NP = 2;
    localparam int NB = 2;
    localparam int NPR = 5;
    localparam int AW = 6;

    logic                 clk, reset;
    logic [NP*AW-1:0]     s_address;
    logic [NP-1:0]        s_read, s_write;
    logic [NP*32-1:0]     s_readdata, s_writedata;
    logic [NPR*32-1:0]    probe_in;
    logic [31:0]          pc_if;
    logic                 core_en, halted, bp_hit;

    core_debug_ctrl #(.NUM_PORTS(NP), .NUM_PROBES(NPR), .NUM_BP(NB), .CYCLE_W(64), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .s_address(s_address), .s_read(s_read),
        .s_readdata(s_readdata), .s_write(s_write), .s_writedata(s_writedata),
        .probe_in(probe_in), .pc_if(pc_if), .core_en(core_en), .halted(halted), .bp_hit(bp_hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rdata(input int p);
        return s_readdata[p*32 +: 32];
    endfunction

    // ---------------- model ----------------
    int              mstate;      // 0 run, 1 halt, 2 step
    longint unsigned mcycle;
    bit              msm, mhit, mskip;
    bit [NB-1:0]     mbp_en;
    logic [31:0]     msteps, midx;
    logic [31:0]     mbp [NB];
    logic [31:0]     mrd [NP];

    task automatic m_reset();
        mstate = 0; mcycle = 0; msm = 0; mhit = 0; mskip = 0; mbp_en = '0;
        msteps = 0; midx = 0;
        for (int k = 0; k < NB; k++) mbp[k] = 0;
        for (int p = 0; p < NP; p++) mrd[p] = 0;
    endtask

    function automatic logic [31:0] m_word(input int idx);
        logic [31:0] r;
        r = 0;
        if (idx == 0) r = mcycle[31:0];
        else if (idx == 1) r = mcycle[63:32];
        else if (idx == 2) r = {27'd0, mbp_en, 2'b00, msm};
        else if (idx == 3) r = msteps;
        else if (idx == 4) r = (midx << 8) | (mhit ? 32'h4 : 32'h0) | 32'(mstate);
        else if (idx >= 5 && idx < 5 + NB) r = mbp[idx-5];
        else if (idx >= 5 + NB && idx < 5 + NB + NPR) r = probe_in[(idx-5-NB)*32 +: 32];
        return r;
    endfunction

    task automatic model_cycle();
        bit          claimed [16];
        logic [31:0] wv [16];
        int          first, ns, idx;
        bit          hreq, res, match, en;
        logic [31:0] nsteps;
        if (reset) m_reset();
        for (int w = 0; w < 16; w++) begin claimed[w] = 0; wv[w] = 0; end
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                if (s_write[p]) begin
                    idx = int'(s_address[p*AW+2 +: 4]);
                    if (!claimed[idx]) begin claimed[idx] = 1; wv[idx] = s_writedata[p*32 +: 32]; end
                end
            end
        end
        hreq = claimed[2] && wv[2][1];
        res  = claimed[2] && wv[2][2];
        first = -1;
        for (int k = 0; k < NB; k++)
            if (first < 0 && mbp_en[k] && pc_if == mbp[k]) first = k;
        match = (first >= 0) && !mskip;
        en = (mstate == 0 && !match && !hreq && !msm) || mstate == 2;

        chk("core_en", 32'(core_en), 32'(en));
        chk("halted", 32'(halted), 32'(mstate == 1));
        chk("bp_hit", 32'(bp_hit), 32'(mhit));
        for (int p = 0; p < NP; p++) chk($sformatf("readdata%0d", p), rdata(p), mrd[p]);
        if (reset) return;

        for (int p = 0; p < NP; p++)
            if (s_read[p]) mrd[p] = m_word(int'(s_address[p*AW+2 +: 4]));

        if (en) begin mcycle++; mskip = 0; end
        ns = mstate;
        nsteps = claimed[3] ? wv[3] : msteps;
        if (mstate == 0) begin
            if (hreq || msm || match) begin
                ns = 1;
                if (match) begin mhit = 1; midx = 32'(first); end
            end
        end else if (mstate == 1) begin
            if (msteps != 0) ns = 2;
            else if (res && !wv[2][0]) begin ns = 0; mhit = 0; mskip = 1; end
        end else begin
            if (hreq) begin ns = 1; nsteps = 0; end
            else if (claimed[3]) begin if (wv[3] == 0) ns = 1; end
            else if (msteps <= 1) begin ns = 1; nsteps = 0; end
            else nsteps = msteps - 1;
        end
        if (claimed[2]) begin
            msm = wv[2][0];
            for (int k = 0; k < NB; k++) mbp_en[k] = wv[2][3+k];
        end
        for (int k = 0; k < NB; k++) if (claimed[5+k]) mbp[k] = wv[5+k];
        mstate = ns;
        msteps = nsteps;
    endtask

    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            model_cycle();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        s_write = '0;
        s_read  = '0;
    endtask

    task automatic wr(input int p, input int idx, input logic [31:0] d);
        s_write[p] = 1'b1;
        s_address[p*AW +: AW] = AW'(idx * 4);
        s_writedata[p*32 +: 32] = d;
    endtask

    task automatic rd(input int p, input int idx);
        s_read[p] = 1'b1;
        s_address[p*AW +: AW] = AW'(idx * 4);
    endtask

    int en_cnt;

    initial begin
        reset = 1'b1; s_address = '0; s_read = '0; s_write = '0; s_writedata = '0; pc_if = '0;
        for (int i = 0; i < NPR; i++) probe_in[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst core_en", 32'(core_en), 32'd1);
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst rdata0", rdata(0), 32'd0);

        // Idle count, dual-port read with one-cycle latency
        repeat (10) tick();
        rd(0, 0); rd(1, 0);
        #1 chk("rd latency", rdata(0), 32'd0);
        tick(); clr();
        chk("cycle_l p0", rdata(0), 32'd10);
        chk("cycle_l p1", rdata(1), 32'd10);

        // Step mode, three steps
        wr(0, 2, 32'h1); tick(); clr();
        wr(0, 3, 32'd3); tick(); clr();
        en_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (core_en) en_cnt++;
            tick();
        end
        chk("step count", 32'(en_cnt), 32'd3);
        chk("step halted", 32'(halted), 32'd1);
        rd(0, 0); rd(1, 3); tick(); clr();
        chk("cycle after step", rdata(0), 32'd15);
        chk("steps drained", rdata(1), 32'd0);

        // Write priority on STEPS, concurrent writes to different regs, halt in STEP
        wr(0, 3, 32'd5); wr(1, 3, 32'd9); tick(); clr();
        rd(0, 3); tick(); clr();
        chk("steps prio", rdata(0), 32'd5);
        wr(0, 3, 32'd100); wr(1, 6, 32'h80); tick(); clr();
        wr(0, 2, 32'h3); tick(); clr();
        chk("halt in step", 32'(halted), 32'd1);
        rd(0, 3); rd(1, 6); tick(); clr();
        chk("steps cleared", rdata(0), 32'd0);
        chk("bp1 addr", rdata(1), 32'h80);
        wr(0, 2, 32'h5); tick(); clr();
        chk("resume stepmode", 32'(halted), 32'd1);
        wr(0, 2, 32'h4); tick(); clr();
        chk("resumed", 32'(halted), 32'd0);

        // Breakpoint 0
        wr(0, 5, 32'h40); pc_if = 32'h3C; tick(); clr();
        wr(0, 2, 32'h8); tick(); clr();
        chk("no bp yet", 32'(core_en), 32'd1);
        pc_if = 32'h40;
        #1 chk("bp same cycle", 32'(core_en), 32'd0);
        tick();
        chk("bp halted", 32'(halted), 32'd1);
        rd(0, 4); tick(); clr();
        chk("status bp0", rdata(0), 32'h005);
        wr(0, 2, 32'hC); tick(); clr();
        chk("skip en", 32'(core_en), 32'd1);
        chk("skip bp_hit", 32'(bp_hit), 32'd0);
        pc_if = 32'h44; tick();
        chk("past bp", 32'(halted), 32'd0);

        // Breakpoint 1 index, CTRL readback, probe and unmapped reads
        wr(0, 2, 32'h18); pc_if = 32'h80; tick(); clr();
        chk("bp1 stall", 32'(core_en), 32'd0);
        tick();
        rd(0, 4); rd(1, 2); tick(); clr();
        chk("status bp1", rdata(0), 32'h105);
        chk("ctrl rb", rdata(1), 32'h18);
        wr(1, 15, 32'hFFFF_FFFF); rd(0, 9); tick(); clr();
        rd(1, 15); tick(); clr();
        chk("probe2", rdata(0), 32'hC0DE_0002);
        chk("unmapped", rdata(1), 32'd0);
        wr(0, 2, 32'h4); pc_if = 32'h100; tick(); clr();

        // Asynchronous reset mid-STEP
        wr(0, 2, 32'h1); tick(); clr();
        wr(0, 3, 32'd100); tick(); clr();
        repeat (2) tick();
        rd(0, 2); rd(1, 9); tick(); clr();
        chk("pre rst ctrl", rdata(0), 32'h1);
        chk("pre rst en", 32'(core_en), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async rdata0", rdata(0), 32'd0);
        chk("async rdata1", rdata(1), 32'd0);
        chk("async core_en", 32'(core_en), 32'd1);
        chk("async halted", 32'(halted), 32'd0);
        tick();
        reset = 1'b0;
        rd(0, 3); rd(1, 2); tick(); clr();
        chk("post rst steps", rdata(0), 32'd0);
        chk("post rst ctrl", rdata(1), 32'd0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
